// File: rtl/monitor_reloj_8f_pkg.sv
// Shared encodings for the clk_f / clk_2f relationship monitor.
// Expected half-periods are in clk_8f cycles; a miss is flagged one cycle after the expected edge.
package monitor_reloj_8f_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } estado_t;

  localparam logic [2:0] HALF_F    = 3'd4;
  localparam logic [2:0] HALF_2F   = 3'd2;
  localparam logic [2:0] MISS_F    = HALF_F + 3'd1;
  localparam logic [2:0] MISS_2F   = HALF_2F + 3'd1;
  localparam logic [2:0] DIST_MAX  = 3'd7;
  localparam int         ERR_W     = 8;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + {{(ERR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/detector_flancos.sv
// Registers one divided clock as data, reports edge/rising and a saturating distance since its last edge.
// Edge outputs are valid one cycle after the pin changes; no backpressure.
module detector_flancos
  import monitor_reloj_8f_pkg::*;
(
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       sig_i,
  output logic       edge_o,
  output logic       rise_o,
  output logic [2:0] dist_o
);

  logic       s_q;
  logic       p_q;
  logic [2:0] d_q;
  logic [2:0] d_d;

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      s_q <= 1'b0;
      p_q <= 1'b0;
      d_q <= 3'd1;
    end else begin
      s_q <= sig_i;
      p_q <= s_q;
      d_q <= d_d;
    end
  end

  assign edge_o = s_q ^ p_q;
  assign rise_o = s_q & ~p_q;
  assign dist_o = d_q;

  // Distance restarts at 1 so that the value seen at the next edge equals the spacing.
  always_comb begin
    d_d = d_q;
    if (edge_o) begin
      d_d = 3'd1;
    end else if (d_q != DIST_MAX) begin
      d_d = d_q + 3'd1;
    end
  end

endmodule

// File: rtl/monitor_reloj_8f.sv
// Qualifies clk_f/clk_2f against ideal /8 and /4 of clk_8f; lock, loss-of-lock pulse and count.
// Outputs follow a pin change by 2 clk_8f cycles; no backpressure, always accepts.
module monitor_reloj_8f
  import monitor_reloj_8f_pkg::*;
#(
  parameter int unsigned LOCK_EDGES = 4
) (
  input  logic             clk_8f,
  input  logic             reset,
  input  logic             clk_f,
  input  logic             clk_2f,
  output logic             locked,
  output logic             error,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       fase
);

  logic       edge_f, rise_f, edge_2f, rise_2f;
  logic [2:0] dist_f, dist_2f;

  detector_flancos u_det_f (
    .clk_8f (clk_8f),
    .reset  (reset),
    .sig_i  (clk_f),
    .edge_o (edge_f),
    .rise_o (rise_f),
    .dist_o (dist_f)
  );

  detector_flancos u_det_2f (
    .clk_8f (clk_8f),
    .reset  (reset),
    .sig_i  (clk_2f),
    .edge_o (edge_2f),
    .rise_o (rise_2f),
    .dist_o (dist_2f)
  );

  estado_t          state_q, state_d;
  logic [3:0]       good_q, good_d, good_inc;
  logic             error_q, error_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;
  logic [2:0]       fase_q, fase_d;
  logic             viol_f, viol_2f, viol;

  // Missed edges are caught one cycle late, when the distance passes the ideal spacing.
  assign viol_2f  = (edge_2f && (dist_2f != HALF_2F)) || (!edge_2f && (dist_2f == MISS_2F));
  assign viol_f   = (edge_f && (dist_f != HALF_F)) || (!edge_f && (dist_f == MISS_F))
                  || (edge_f && !rise_2f);
  assign viol     = viol_f || viol_2f;
  assign good_inc = good_q + 4'd1;

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state_q <= SEARCH;
      good_q  <= 4'd0;
      error_q <= 1'b0;
      cnt_q   <= '0;
      fase_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      error_q <= error_d;
      cnt_q   <= cnt_d;
      fase_q  <= fase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    error_d = 1'b0;
    cnt_d   = cnt_q;
    fase_d  = rise_f ? 3'd0 : fase_q + 3'd1;
    unique case (state_q)
      SEARCH: begin
        if (edge_f && rise_2f) begin
          good_d  = 4'd0;
          state_d = TRACK;
        end
      end
      TRACK: begin
        // A violation on the lock-completing edge still sends us back to SEARCH.
        if (viol) begin
          state_d = SEARCH;
        end else if (edge_f) begin
          good_d = good_inc;
          if (good_inc == LOCK_EDGES[3:0]) begin
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (viol) begin
          state_d = SEARCH;
          error_d = 1'b1;
          cnt_d   = sat_inc(cnt_q);
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  assign locked    = (state_q == LOCKED);
  assign error     = error_q;
  assign err_count = cnt_q;
  assign fase      = fase_q;

endmodule

// File: tb/tb_monitor_reloj_8f.sv
// Directed bench for monitor_reloj_8f: pin-history reference model checked every cycle plus literal timing pins.
module tb_monitor_reloj_8f;

  localparam int LOCK_EDGES = 4;
  localparam int HMAX       = 32768;
  localparam int M_SEARCH   = 0;
  localparam int M_TRACK    = 1;
  localparam int M_LOCKED   = 2;

  logic       clk_8f = 1'b0;
  logic       reset  = 1'b0;
  logic       clk_f  = 1'b0;
  logic       clk_2f = 1'b0;
  logic       locked;
  logic       error;
  logic [7:0] err_count;
  logic [2:0] fase;

  monitor_reloj_8f #(.LOCK_EDGES(LOCK_EDGES)) dut (
    .clk_8f    (clk_8f),
    .reset     (reset),
    .clk_f     (clk_f),
    .clk_2f    (clk_2f),
    .locked    (locked),
    .error     (error),
    .err_count (err_count),
    .fase      (fase)
  );

  always #5 clk_8f = ~clk_8f;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Stimulus generator: ph walks the ideal 8-cycle pattern; flags bend it for faults.
  logic [2:0] ph     = 3'd2;
  bit         f_hold = 1'b0;
  bit         inv2f  = 1'b0;
  bit         glitch = 1'b0;

  task automatic drive();
    clk_f  = ph[2] | f_hold;
    clk_2f = ~ph[1] ^ inv2f ^ glitch;
  endtask

  task automatic tick();
    @(posedge clk_8f);
    #1;
    ph = ph + 3'd1;
    drive();
  endtask

  // Reference model: keeps the sampled pin history and the cycle number of the last edges.
  bit hf [HMAX];
  bit h2 [HMAX];
  int c = -1, last_f = -2, last_2 = -2, last_rf = -2, mode = M_SEARCH, good = 0;
  bit m_locked = 0, m_error = 0;
  int m_cnt = 0, m_fase = 0;

  always @(posedge clk_8f or negedge reset) begin : model
    bit sf, pf, s2, p2, ef, rf, e2, r2, viol;
    int d1, d2;
    if (!reset) begin
      c = -1; last_f = -2; last_2 = -2; last_rf = -2;
      mode = M_SEARCH; good = 0;
      m_locked = 0; m_error = 0; m_cnt = 0; m_fase = 0;
    end else begin
      sf = (c >= 0) ? hf[c] : 1'b0;
      pf = (c >= 1) ? hf[c-1] : 1'b0;
      s2 = (c >= 0) ? h2[c] : 1'b0;
      p2 = (c >= 1) ? h2[c-1] : 1'b0;
      ef = (sf != pf);
      rf = sf && !pf;
      e2 = (s2 != p2);
      r2 = s2 && !p2;
      d1 = c - last_f; if (d1 > 7) d1 = 7;
      d2 = c - last_2; if (d2 > 7) d2 = 7;
      viol = (mode != M_SEARCH) &&
             ((e2 && d2 != 2) || (!e2 && d2 == 3) ||
              (ef && d1 != 4) || (!ef && d1 == 5) || (ef && !r2));
      m_error = 0;
      if (mode == M_SEARCH) begin
        if (ef && r2) begin good = 0; mode = M_TRACK; end
      end else if (mode == M_TRACK) begin
        if (viol) mode = M_SEARCH;
        else if (ef) begin
          good = good + 1;
          if (good == LOCK_EDGES) mode = M_LOCKED;
        end
      end else begin
        if (viol) begin
          mode = M_SEARCH;
          m_error = 1;
          if (m_cnt < 255) m_cnt = m_cnt + 1;
        end
      end
      if (ef) last_f = c;
      if (e2) last_2 = c;
      if (rf) last_rf = c;
      m_fase   = (c - last_rf) % 8;
      m_locked = (mode == M_LOCKED);
      if (c < HMAX - 2) begin
        c = c + 1;
        hf[c] = clk_f;
        h2[c] = clk_2f;
      end
    end
  end

  always @(negedge clk_8f) begin
    if (cmp_en) begin
      chk("model locked", 32'(locked), 32'(m_locked));
      chk("model error", 32'(error), 32'(m_error));
      chk("model err_count", 32'(err_count), 32'(m_cnt));
      chk("model fase", 32'(fase), 32'(m_fase));
      if (error === 1'b1) pulses++;
    end
  end

  // Ticks up to the next qualifying clk_f edge; lock must appear 18 ticks after it is driven.
  task automatic relock_check(input string name);
    do tick(); while (ph[1:0] != 2'd0);
    repeat (17) tick();
    chk({name, " locked early"}, 32'(locked), 32'd0);
    tick();
    chk({name, " locked"}, 32'(locked), 32'd1);
  endtask

  task automatic hold_reset(input bit inv);
    @(posedge clk_8f);
    #2;
    reset = 1'b0;
    inv2f = inv;
    f_hold = 1'b0;
    glitch = 1'b0;
    ph = 3'd2;
    drive();
    repeat (3) @(posedge clk_8f);
    #1;
    reset = 1'b1;
  endtask

  task automatic fault_f(input int exp_cnt);
    while (ph != 3'd4) tick();
    repeat (3) tick();
    f_hold = 1'b1;
    repeat (2) tick();
    f_hold = 1'b0;
    tick();
    chk("hold error before", 32'(error), 32'd0);
    chk("hold locked before", 32'(locked), 32'd1);
    tick();
    chk("hold error pulse", 32'(error), 32'd1);
    chk("hold locked dropped", 32'(locked), 32'd0);
    chk("hold err_count", 32'(err_count), 32'(exp_cnt));
    relock_check("hold relock");
  endtask

  task automatic glitch_fault();
    while (ph != 3'd4) tick();
    chk("glitch locked before", 32'(locked), 32'd1);
    glitch = 1'b1;
    tick();
    glitch = 1'b0;
    relock_check("glitch relock");
  endtask

  int exp_fase [8] = '{1, 2, 3, 4, 5, 6, 7, 0};

  initial begin
    int p0;
    ph = 3'd2;
    drive();
    repeat (3) @(posedge clk_8f);
    #1;
    cmp_en = 1'b1;
    chk("reset locked", 32'(locked), 32'd0);
    chk("reset error", 32'(error), 32'd0);
    chk("reset err_count", 32'(err_count), 32'd0);
    chk("reset fase", 32'(fase), 32'd0);
    reset = 1'b1;

    relock_check("first lock");
    chk("first lock err_count", 32'(err_count), 32'd0);

    while (ph != 3'd4) tick();
    tick();
    tick();
    chk("fase zero", 32'(fase), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("fase step", 32'(fase), 32'(exp_fase[i]));
    end

    for (int i = 1; i <= 3; i++) fault_f(i);
    chk("err_count before reset", 32'(err_count), 32'd3);

    @(posedge clk_8f);
    #2;
    reset = 1'b0;
    #1;
    chk("async locked", 32'(locked), 32'd0);
    chk("async error", 32'(error), 32'd0);
    chk("async err_count", 32'(err_count), 32'd0);
    chk("async fase", 32'(fase), 32'd0);
    hold_reset(1'b0);
    relock_check("lock after reset");
    chk("err_count after reset", 32'(err_count), 32'd0);

    hold_reset(1'b1);
    for (int i = 0; i < 64; i++) begin
      tick();
      chk("inverted locked", 32'(locked), 32'd0);
    end
    chk("inverted err_count", 32'(err_count), 32'd0);

    hold_reset(1'b0);
    relock_check("lock before glitches");
    p0 = pulses;
    repeat (300) glitch_fault();
    chk("glitch err_count saturated", 32'(err_count), 32'd255);
    chk("glitch pulse count", 32'(pulses - p0), 32'd300);

    repeat (2) @(posedge clk_8f);
    #1;
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
